muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, for the MIPS datapath.
- Sits downstream of the register file: it takes rd1/rd2 as operands a/b. Its hi/lo outputs feed the writeback mux for MFHI/MFLO.
- Runs one radix-2 step per cycle (32 steps) so the adder stays on the single-cycle critical path budget.
- The controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- Internal step-counter width is $clog2(WIDTH)+1.

Ports:
- clk    input   1      clock; all state updates on the rising edge
- reset  input   1      asynchronous, active-high reset
- start  input   1      begin operation op on operands a, b (sampled when idle)
- op     input   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a      input   WIDTH  operand 1 (multiplicand/dividend); also MTHI/MTLO data
- b      input   WIDTH  operand 2 (multiplier/divisor)
- mthi   input   1      write a into HI (idle only)
- mtlo   input   1      write a into LO (idle only)
- busy   output  1      operation in progress
- done   output  1      one-cycle pulse: HI/LO updated at the preceding edge
- hi     output  WIDTH  HI register (product upper half / remainder)
- lo     output  WIDTH  LO register (product lower half / quotient)

Behaviour:

Reset and idle:
- Reset is asynchronous: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, operand latches=0.
- Reset mid-operation aborts the operation; no partial result is ever written to HI/LO.

FSM states: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch |a|, |b| (absolute values for signed ops, raw values for unsigned ops).
  - Record result signs: sq = a[W-1]^b[W-1]; sr = a[W-1] (signed ops only).
  - Record op, clear the accumulator, counter=0, go to RUN.
  - busy=1 from E0 onward.
- RUN: one step per edge, E1..E32.
  - Multiply: shift-add, LSB-first over the multiplier; 2W-bit accumulator.
  - Divide: restoring shift-subtract; W-bit partial remainder plus quotient shift register.
  - After the 32nd step, go to FIX.
- FIX at edge E33:
  - Apply sign correction: negate the product if sq (mult); negate the quotient if sq and the remainder if sr (div).
  - Write HI/LO, go to IDLE.
  - busy=0 and done=1 for exactly the cycle after E33.
- Latency: result visible on hi/lo 33 edges after start is sampled. Fixed, independent of operand values.

Priority and contention rules:
- start while busy=1 is ignored; the operation in progress is unaffected.
- mthi/mtlo while busy=1 are ignored.
- start and mthi/mtlo in the same IDLE cycle: start wins and the writes are dropped.
- mthi and mtlo together: both written with a.
- hi/lo hold their value during RUN; only the old HI/LO are visible until E33.
- done is asserted only from FIX, never from mthi/mtlo.

Arithmetic and boundary cases:
- Multiply: the full 2W-bit product, with {hi,lo} = product; two's complement for signed ops.
- Divide by zero (b=0), signed or unsigned: full latency is still taken; LO=all-ones, HI=a (raw dividend).
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- A start accepted in the cycle where done=1 is legal; back-to-back operations are supported.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=5 -> after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFF1, one-cycle done pulse, busy high for exactly 33 cycles.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands -> hi=0, lo=1.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
4. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 edges. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Contention:
   - During RUN, drive start with new operands plus mthi=1, a=0xDEAD -> ignored, and the original result lands on E33.
   - In IDLE, mtlo=1 with a=0xCAFE -> lo=0xCAFE next cycle, hi unchanged, done stays 0.
6. Assert reset at step 10 of a DIVU -> hi=lo=0, busy=0, done=0 immediately. A fresh MULTU 6*7 then gives hi=0, lo=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned SW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              sq_q, sq_d;
    logic              sr_q, sr_d;
    logic              bz_q, bz_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_signed;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [SW-1:0]     mul_sum;
    logic [AW-1:0]     mul_next;
    logic [SW-1:0]     div_part;
    logic [SW-1:0]     div_diff;
    logic              div_ge;
    logic [AW-1:0]     div_next;
    logic [AW-1:0]     prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix;

    // Operand magnitudes: signed ops work on absolute values, signs fixed up in FIX.
    always_comb begin
        is_signed = ~op[0];
        a_abs     = (is_signed && a[WIDTH-1]) ? WIDTH'(~a + WIDTH'(1)) : a;
        b_abs     = (is_signed && b[WIDTH-1]) ? WIDTH'(~b + WIDTH'(1)) : b;
    end

    // Datapath for one step: acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : SW'(0));
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_part = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_part - {1'b0, opnd_q};
        div_ge   = (div_part >= {1'b0, opnd_q});
        div_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[AW-2:0], 1'b0};
        prod_fix = sq_q ? AW'(~acc_q + AW'(1)) : acc_q;
        quo_fix  = bz_q ? {WIDTH{1'b1}}
                 : (sq_q ? WIDTH'(~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0]);
        rem_fix  = sr_q ? WIDTH'(~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        bz_d    = bz_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    sq_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sr_d    = is_signed & a[WIDTH-1];
                    bz_d    = (b == '0);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                    if (op[1]) begin
                        opnd_d = b_abs;
                        acc_d  = {{WIDTH{1'b0}}, a_abs};
                    end else begin
                        opnd_d = a_abs;
                        acc_d  = {{WIDTH{1'b0}}, b_abs};
                    end
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[AW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            bz_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            bz_q    <= bz_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
